// File: rtl/rat_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rat_dispatch_ctrl
// Brief    : Dispatch sequencer in front of the RAT. It allocates ROB tags,
//            reads source mappings, renames the destination and issues
//            operand packets to the reservation station.
//            Optional macro SAME_SRC_BYPASS_EN: a single RAT read is made
//            when src1 == src2.
// Revision : 1.0 - initial release
// ============================================================================
module rat_dispatch_ctrl #(
  parameter int ROB_DEPTH = 4,
  parameter int TAG_W     = 2,
  parameter int ARCH_W    = 2,
  parameter int DATA_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_dec_valid,
  output logic              o_dec_ready,
  input  logic [ARCH_W-1:0] i_dec_src1,
  input  logic [ARCH_W-1:0] i_dec_src2,
  input  logic [ARCH_W-1:0] i_dec_dst,
  output logic              o_rat_rs_req,
  output logic [ARCH_W-1:0] o_rat_rs_addr,
  input  logic              i_rat_tag_valid,
  input  logic [TAG_W-1:0]  i_rat_tag,
  input  logic              i_rat_val_valid,
  input  logic [DATA_W-1:0] i_rat_val,
  output logic              o_rat_rob_valid,
  output logic [TAG_W-1:0]  o_rat_rob_addr,
  output logic [ARCH_W-1:0] o_rat_rob_dst_addr,
  output logic              o_iss_valid,
  input  logic              i_iss_ready,
  output logic [TAG_W-1:0]  o_iss_rob_tag,
  output logic              o_iss_src1_pend,
  output logic              o_iss_src2_pend,
  output logic [TAG_W-1:0]  o_iss_src1_tag,
  output logic [TAG_W-1:0]  o_iss_src2_tag,
  output logic [DATA_W-1:0] o_iss_src1_val,
  output logic [DATA_W-1:0] o_iss_src2_val,
  input  logic              i_cmt_valid,
  output logic [TAG_W:0]    o_rob_count,
  output logic              o_rob_full
);

`ifdef SAME_SRC_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD1  = 3'd1;
  localparam logic [2:0] RD2  = 3'd2;
  localparam logic [2:0] CAP2 = 3'd3;
  localparam logic [2:0] WR   = 3'd4;
  localparam logic [2:0] ISS  = 3'd5;

  localparam logic [TAG_W:0] PTR_ONE = (TAG_W+1)'(1);
  localparam logic [TAG_W:0] DEPTH   = (TAG_W+1)'(ROB_DEPTH);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ARCH_W-1:0] src1;
  logic [ARCH_W-1:0] src2;
  logic [ARCH_W-1:0] dst;
  // Pointers carry one extra wrap bit so that full and empty differ.
  logic [TAG_W:0]    head;
  logic [TAG_W:0]    tail;
  logic [TAG_W:0]    count;
  logic [TAG_W-1:0]  iss_tag;
  logic              s1_pend;
  logic              s2_pend;
  logic [TAG_W-1:0]  s1_tag;
  logic [TAG_W-1:0]  s2_tag;
  logic [DATA_W-1:0] s1_val;
  logic [DATA_W-1:0] s2_val;
  logic              accept;
  logic              alloc;
  logic              commit;
  logic              same_src;
  logic [DATA_W-1:0] rsp_val;

  assign count       = tail - head;
  assign o_rob_count = count;
  assign o_rob_full  = (count == DEPTH);
  assign o_dec_ready = i_rstn && (state == IDLE) && !o_rob_full;
  assign accept      = i_dec_valid && o_dec_ready;
  assign alloc       = (state == WR);
  assign commit      = i_cmt_valid && (count != '0);
  assign same_src    = BYPASS && (src1 == src2);
  // A register with neither a pending tag nor a valid value reads as zero.
  assign rsp_val     = (!i_rat_tag_valid && i_rat_val_valid) ? i_rat_val : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RD1;
      RD1:     state_nxt = RD2;
      RD2:     state_nxt = same_src ? WR : CAP2;
      CAP2:    state_nxt = WR;
      WR:      state_nxt = ISS;
      ISS:     if (i_iss_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_rat_rs_req  = (state == RD1) || ((state == RD2) && !same_src);
    o_rat_rs_addr = '0;
    if (state == RD1)
      o_rat_rs_addr = src1;
    else if (o_rat_rs_req)
      o_rat_rs_addr = src2;
  end

  assign o_rat_rob_valid    = alloc;
  assign o_rat_rob_addr     = alloc ? tail[TAG_W-1:0] : '0;
  assign o_rat_rob_dst_addr = alloc ? dst : '0;

  assign o_iss_valid     = (state == ISS);
  assign o_iss_rob_tag   = iss_tag;
  assign o_iss_src1_pend = s1_pend;
  assign o_iss_src2_pend = s2_pend;
  assign o_iss_src1_tag  = s1_tag;
  assign o_iss_src2_tag  = s2_tag;
  assign o_iss_src1_val  = s1_val;
  assign o_iss_src2_val  = s2_val;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= IDLE;
      src1    <= '0;
      src2    <= '0;
      dst     <= '0;
      head    <= '0;
      tail    <= '0;
      iss_tag <= '0;
      s1_pend <= 1'b0;
      s2_pend <= 1'b0;
      s1_tag  <= '0;
      s2_tag  <= '0;
      s1_val  <= '0;
      s2_val  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        src1 <= i_dec_src1;
        src2 <= i_dec_src2;
        dst  <= i_dec_dst;
      end
      if (alloc) begin
        tail    <= tail + PTR_ONE;
        iss_tag <= tail[TAG_W-1:0];
      end
      if (commit)
        head <= head + PTR_ONE;
      if (state == RD2) begin
        s1_pend <= i_rat_tag_valid;
        s1_tag  <= i_rat_tag;
        s1_val  <= rsp_val;
        if (same_src) begin
          s2_pend <= i_rat_tag_valid;
          s2_tag  <= i_rat_tag;
          s2_val  <= rsp_val;
        end
      end
      if (state == CAP2) begin
        s2_pend <= i_rat_tag_valid;
        s2_tag  <= i_rat_tag;
        s2_val  <= rsp_val;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/rat_dispatch_ctrl.md
Name: rat_dispatch_ctrl

Overview:
Dispatch sequencer in front of the register alias table (RAT). It accepts one decoded instruction at a time and allocates a ROB tag from a circular allocator. It reads both source mappings through the RAT's single read port, writes the new destination mapping into the RAT, and hands a resolved operand packet to the reservation station. In-order commit pulses from the ROB free tags.

Parameters:
ROB_DEPTH, 4, number of ROB entries (power of two)
TAG_W, 2, ROB tag width, log2(ROB_DEPTH)
ARCH_W, 2, architectural register index width
DATA_W, 16, register value width

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_dec_valid  in  1  decoded instruction valid
o_dec_ready  out  1  controller can accept an instruction
i_dec_src1 / i_dec_src2 / i_dec_dst  in  ARCH_W each  source and destination register indices
o_rat_rs_req  out  1  RAT read request
o_rat_rs_addr  out  ARCH_W  RAT read index
i_rat_tag_valid  in  1  RAT: register renamed (pending)
i_rat_tag  in  TAG_W  RAT: producing ROB tag
i_rat_val_valid  in  1  RAT: committed value valid
i_rat_val  in  DATA_W  RAT: committed value
o_rat_rob_valid  out  1  RAT write strobe
o_rat_rob_addr  out  TAG_W  allocated ROB tag
o_rat_rob_dst_addr  out  ARCH_W  destination register being renamed
o_iss_valid  out  1  issue packet valid
i_iss_ready  in  1  reservation station accepts
o_iss_rob_tag  out  TAG_W  instruction's ROB tag
o_iss_src1_pend / o_iss_src2_pend  out  1 each  source waits on tag
o_iss_src1_tag / o_iss_src2_tag  out  TAG_W each  producing tag when pending
o_iss_src1_val / o_iss_src2_val  out  DATA_W each  operand value when not pending
i_cmt_valid  in  1  oldest ROB entry committed, free it
o_rob_count  out  TAG_W+1  occupied ROB entries
o_rob_full  out  1  o_rob_count == ROB_DEPTH

Behaviour:
- Reset (async, i_rstn low): state IDLE; head = tail = 0; count = 0; all outputs 0, except o_dec_ready = 1 after release.
- RAT read latency is fixed at 1: the response to a request driven in cycle N is sampled in cycle N+1.
- o_dec_ready = (state==IDLE) && !o_rob_full. Acceptance on i_dec_valid && o_dec_ready latches src1/src2/dst.
- FSM:
  - IDLE -> RD1 on accept.
  - RD1: req=1, addr=src1 -> RD2.
  - RD2: capture src1 response; req=1, addr=src2 -> CAP2.
  - CAP2: capture src2 response -> WR.
  - WR: o_rat_rob_valid=1 for one cycle, rob_addr=tail, dst_addr=dst. tail++ (mod ROB_DEPTH), count++ -> ISS.
  - ISS: o_iss_valid=1 with fields held stable until i_iss_ready. IDLE follows the handshake.
- Sources are read before the destination is written, so src==dst yields the previous mapping.
- Capture rule per source:
  - pend = i_rat_tag_valid; tag = i_rat_tag.
  - val = i_rat_val when !i_rat_tag_valid, else 0.
  - !tag_valid && !val_valid is treated as value 0, not pending.
- Fastest throughput is one instruction per 6 cycles (accept to next accept with i_iss_ready held high).
- Commit: i_cmt_valid with count>0 -> head++, count--. i_cmt_valid with count==0 is ignored.
  - WR and commit in the same cycle: count unchanged, both pointers advance.
- Full: allocation happens only from an accepted instruction, which requires !full. A commit while full re-enables o_dec_ready the next cycle.
- Pointers wrap modulo ROB_DEPTH; tag 3 is followed by tag 0.
- Reset mid-sequence: in-flight instruction dropped, no RAT write pulse, outputs return to reset values immediately.

Optional Feature:
SAME_SRC_BYPASS_EN
- Defined: if latched src1==src2, RD2 issues no second request. CAP2 is skipped (RD2 -> WR) and src2 fields copy the src1 capture, saving one cycle.
- Undefined: always two reads, as above.

Test Plan:
- Reset released, no stimulus -> o_dec_ready=1, o_rob_count=0, all strobes 0, o_iss_valid=0.
- RAT empty; dispatch src1=0, src2=1, dst=3 -> RAT reads addr 0 then 1; o_rat_rob_valid pulse with addr=0, dst=3; issue tag 0, both pend=0, values from RAT; count=1.
- Dispatch dst=3, then src1=3, dst=2 (model RAT returns tag 0 for r3) -> second issue tag 1, src1_pend=1, src1_tag=0.
- Four dispatches with no commit -> count=4, o_rob_full=1, o_dec_ready=0. One i_cmt_valid -> count=3, ready=1; next allocation tag 0 (wrap).
- WR cycle coincident with i_cmt_valid at count=2 -> count stays 2, head and tail both advance.
- i_iss_ready held low 5 cycles in ISS -> packet stable, no new accept. Reset asserted in RD2 -> no RAT write, state IDLE, count 0. With SAME_SRC_BYPASS_EN and src1=src2=1 -> exactly one RAT read.
